// File: rtl/butterfly2p.sv
// Radix-2 DIT butterfly on binary16 complex operands: result1 = A + W*B, result2 = A - W*B.
// Fully combinational datapath into one output register stage; subnormals flush to zero.

module fp16_mul (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] y_o
);
    logic        sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        hi, grd, stk;
    logic [21:0] prod;
    logic [10:0] sig;
    logic [11:0] rnd;
    logic [9:0]  frac;
    logic [6:0]  ebias, efield;

    always_comb begin
        sgn    = a_i[15] ^ b_i[15];
        a_zero = (a_i[14:10] == 5'd0);
        b_zero = (b_i[14:10] == 5'd0);
        a_inf  = (a_i[14:10] == 5'h1F) && (a_i[9:0] == 10'd0);
        b_inf  = (b_i[14:10] == 5'h1F) && (b_i[9:0] == 10'd0);
        a_nan  = (a_i[14:10] == 5'h1F) && (a_i[9:0] != 10'd0);
        b_nan  = (b_i[14:10] == 5'h1F) && (b_i[9:0] != 10'd0);
        prod   = {11'b0, 1'b1, a_i[9:0]} * {11'b0, 1'b1, b_i[9:0]};
        hi     = prod[21];
        if (hi) begin
            sig = prod[21:11];
            grd = prod[10];
            stk = |prod[9:0];
        end else begin
            sig = prod[20:10];
            grd = prod[9];
            stk = |prod[8:0];
        end
        rnd    = {1'b0, sig} + {11'b0, grd & (stk | sig[0])};
        frac   = rnd[11] ? 10'd0 : rnd[9:0];
        // ebias carries the exponent offset by +15 so the whole range stays unsigned
        ebias  = {2'b0, a_i[14:10]} + {2'b0, b_i[14:10]} + {6'b0, hi} + {6'b0, rnd[11]};
        efield = ebias - 7'd15;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            y_o = 16'h7E00;
        else if (a_inf || b_inf)
            y_o = {sgn, 15'h7C00};
        else if (a_zero || b_zero || (ebias < 7'd16))
            y_o = {sgn, 15'h0000};
        else if (ebias > 7'd45)
            y_o = {sgn, 15'h7C00};
        else
            y_o = {sgn, efield[4:0], frac};
    end
endmodule

module fp16_add (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sub_i,
    output logic [15:0] y_o
);
    logic [15:0] bx, big, sml;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, found, grd, stk;
    logic [4:0]  d;
    logic [3:0]  dc, lz, sh;
    logic [27:0] ext;
    logic [14:0] am, bm, s;
    logic [13:0] n;
    logic [10:0] sig;
    logic [11:0] rnd;
    logic [9:0]  frac;
    logic [6:0]  ebias, efield;

    always_comb begin
        bx     = {b_i[15] ^ sub_i, b_i[14:0]};
        a_zero = (a_i[14:10] == 5'd0);
        b_zero = (bx[14:10] == 5'd0);
        a_inf  = (a_i[14:10] == 5'h1F) && (a_i[9:0] == 10'd0);
        b_inf  = (bx[14:10] == 5'h1F) && (bx[9:0] == 10'd0);
        a_nan  = (a_i[14:10] == 5'h1F) && (a_i[9:0] != 10'd0);
        b_nan  = (bx[14:10] == 5'h1F) && (bx[9:0] != 10'd0);
        if (a_i[14:0] >= bx[14:0]) begin
            big = a_i;
            sml = bx;
        end else begin
            big = bx;
            sml = a_i;
        end
        d   = big[14:10] - sml[14:10];
        dc  = (d > 5'd15) ? 4'd15 : d[3:0];
        // three guard bits plus a sticky bit give exact round-to-nearest-even
        ext = {1'b1, sml[9:0], 3'b000, 14'b0} >> dc;
        am  = {2'b01, big[9:0], 3'b000};
        bm  = {1'b0, ext[27:15], ext[14] | (|ext[13:0])};
        s   = (big[15] == sml[15]) ? am + bm : am - bm;
        lz    = 4'd0;
        found = 1'b0;
        for (int i = 14; i >= 0; i--) begin
            if (!found && s[i]) begin
                lz    = 4'(14 - i);
                found = 1'b1;
            end
        end
        sh = 4'd0;
        if (s[14]) begin
            n     = {s[14:2], s[1] | s[0]};
            ebias = {2'b0, big[14:10]} + 7'd17;
        end else begin
            sh    = lz - 4'd1;
            n     = s[13:0] << sh;
            ebias = {2'b0, big[14:10]} + 7'd16 - {3'b0, sh};
        end
        sig    = n[13:3];
        grd    = n[2];
        stk    = |n[1:0];
        rnd    = {1'b0, sig} + {11'b0, grd & (stk | sig[0])};
        frac   = rnd[11] ? 10'd0 : rnd[9:0];
        ebias  = ebias + {6'b0, rnd[11]};
        efield = ebias - 7'd16;
        if (a_nan || b_nan || (a_inf && b_inf && (a_i[15] != bx[15])))
            y_o = 16'h7E00;
        else if (a_inf)
            y_o = {a_i[15], 15'h7C00};
        else if (b_inf)
            y_o = {bx[15], 15'h7C00};
        else if (a_zero && b_zero)
            y_o = {a_i[15] & bx[15], 15'h0000};
        else if (a_zero)
            y_o = bx;
        else if (b_zero)
            y_o = a_i;
        else if (s == 15'd0)
            y_o = 16'h0000;
        else if (ebias < 7'd17)
            y_o = {big[15], 15'h0000};
        else if (ebias > 7'd46)
            y_o = {big[15], 15'h7C00};
        else
            y_o = {big[15], efield[4:0], frac};
    end
endmodule

module butterfly2p (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic [2:0]  twiddle_index,
    output logic [31:0] result1,
    output logic [31:0] result2
);
    localparam logic [15:0] C  = 16'h39A8;
    localparam logic [15:0] NC = 16'hB9A8;

    logic [15:0]       w_re, w_im, m_rr, m_ii, m_ri, m_ir, p_re, p_im;
    logic [3:0][15:0]  o_a, o_b, o_y;
    logic [3:0]        o_sub;
    logic [31:0]       result1_d, result2_d, result1_q, result2_q;

    always_comb begin
        case (twiddle_index)
            3'd0:    {w_re, w_im} = {16'h3C00, 16'h0000};
            3'd1:    {w_re, w_im} = {C,        NC};
            3'd2:    {w_re, w_im} = {16'h0000, 16'hBC00};
            3'd3:    {w_re, w_im} = {NC,       NC};
            3'd4:    {w_re, w_im} = {16'hBC00, 16'h0000};
            3'd5:    {w_re, w_im} = {NC,       C};
            3'd6:    {w_re, w_im} = {16'h0000, 16'h3C00};
            default: {w_re, w_im} = {C,        C};
        endcase
    end

    fp16_mul u_mul_rr (.a_i(num2[31:16]), .b_i(w_re), .y_o(m_rr));
    fp16_mul u_mul_ii (.a_i(num2[15:0]),  .b_i(w_im), .y_o(m_ii));
    fp16_mul u_mul_ri (.a_i(num2[31:16]), .b_i(w_im), .y_o(m_ri));
    fp16_mul u_mul_ir (.a_i(num2[15:0]),  .b_i(w_re), .y_o(m_ir));

    fp16_add u_add_pre (.a_i(m_rr), .b_i(m_ii), .sub_i(1'b1), .y_o(p_re));
    fp16_add u_add_pim (.a_i(m_ri), .b_i(m_ir), .sub_i(1'b0), .y_o(p_im));

    // lanes: 0 = r1.re, 1 = r1.im, 2 = r2.re, 3 = r2.im
    assign o_a   = {num1[15:0], num1[31:16], num1[15:0], num1[31:16]};
    assign o_b   = {p_im, p_re, p_im, p_re};
    assign o_sub = 4'b1100;

    for (genvar g = 0; g < 4; g++) begin : g_out
        fp16_add u_add (.a_i(o_a[g]), .b_i(o_b[g]), .sub_i(o_sub[g]), .y_o(o_y[g]));
    end

    assign result1_d = {o_y[0], o_y[1]};
    assign result2_d = {o_y[2], o_y[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result1_q <= 32'h0;
            result2_q <= 32'h0;
        end else begin
            result1_q <= result1_d;
            result2_q <= result2_d;
        end
    end

    assign result1 = result1_q;
    assign result2 = result2_q;
endmodule

// File: tb/tb_butterfly2p.sv
// Bench for butterfly2p: real-arithmetic binary16 reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_butterfly2p;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] num1, num2;
    logic [2:0]  twiddle_index;
    logic [31:0] result1, result2;
    int          n_pass = 0, n_chk = 0;

    localparam logic [31:0] WTAB [0:7] = '{32'h3C000000, 32'h39A8B9A8, 32'h0000BC00, 32'hB9A8B9A8,
                                           32'hBC000000, 32'hB9A839A8, 32'h00003C00, 32'h39A839A8};

    butterfly2p dut (.clk(clk), .rst_n(rst_n), .num1(num1), .num2(num2),
                     .twiddle_index(twiddle_index), .result1(result1), .result2(result2));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic logic is_zero(input logic [15:0] h); return h[14:10] == 5'd0; endfunction
    function automatic logic is_inf(input logic [15:0] h); return h[14:0] == 15'h7C00; endfunction
    function automatic logic is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        if (is_zero(h)) return 0.0;
        v = real'(int'(h[9:0]) + 1024) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -v : v;
    endfunction

    // round a nonzero finite real to binary16, nearest-even, flush tiny, saturate to inf
    function automatic logic [15:0] r2h(input real x);
        logic s = (x < 0.0);
        real  a = s ? -x : x;
        int   e = 0;
        real  m, r;
        int   f;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = a * 1024.0;
        f = $rtoi(m);
        r = m - real'(f);
        if (r > 0.5 || (r == 0.5 && (f % 2) == 1)) f++;
        if (f == 2048) begin f = 1024; e++; end
        if (e < -14) return {s, 15'h0000};
        if (e > 15) return {s, 15'h7C00};
        return {s, 5'(e + 15), 10'(f - 1024)};
    endfunction

    function automatic logic [15:0] mmul(input logic [15:0] a, input logic [15:0] b);
        logic s = a[15] ^ b[15];
        if (is_nan(a) || is_nan(b)) return 16'h7E00;
        if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return 16'h7E00;
        if (is_inf(a) || is_inf(b)) return {s, 15'h7C00};
        if (is_zero(a) || is_zero(b)) return {s, 15'h0000};
        return r2h(h2r(a) * h2r(b));
    endfunction

    function automatic logic [15:0] madd(input logic [15:0] a, input logic [15:0] b);
        real x;
        if (is_nan(a) || is_nan(b)) return 16'h7E00;
        if (is_inf(a) && is_inf(b) && a[15] != b[15]) return 16'h7E00;
        if (is_inf(a)) return {a[15], 15'h7C00};
        if (is_inf(b)) return {b[15], 15'h7C00};
        x = h2r(a) + h2r(b);
        if (x == 0.0) return (is_zero(a) && is_zero(b)) ? {a[15] & b[15], 15'h0000} : 16'h0000;
        return r2h(x);
    endfunction

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] k);
        logic [31:0] w = WTAB[k];
        logic [15:0] pr, pi;
        pr = madd(mmul(b[31:16], w[31:16]), mmul(b[15:0], w[15:0]) ^ 16'h8000);
        pi = madd(mmul(b[31:16], w[15:0]), mmul(b[15:0], w[31:16]));
        return {madd(a[31:16], pr), madd(a[15:0], pi),
                madd(a[31:16], pr ^ 16'h8000), madd(a[15:0], pi ^ 16'h8000)};
    endfunction

    // every-cycle comparison against the model
    initial begin
        logic [63:0] e;
        forever begin
            @(posedge clk);
            e = rst_n ? model(num1, num2, twiddle_index) : 64'h0;
            #1;
            chk("stream", {result1, result2}, e);
        end
    end

    task automatic apply(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] k, input logic [63:0] exp);
        @(negedge clk);
        num1 = a; num2 = b; twiddle_index = k;
        @(posedge clk);
        #1;
        chk(nm, {result1, result2}, exp);
    endtask

    function automatic logic [15:0] rh();
        logic [15:0] sp [0:9] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                                  16'h0001, 16'h8200, 16'h7BFF, 16'h0400, 16'h3C00};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 9)];
        return 16'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0;
        num1 = 32'h12345678; num2 = 32'h9ABCDEF0; twiddle_index = 3'd5;
        repeat (3) begin
            @(negedge clk);
            num1 = $urandom; num2 = $urandom; twiddle_index = 3'($urandom);
        end
        chk("reset_hold", {result1, result2}, 64'h0);

        chk("model_negj", model(32'hC2000000, 32'h3C000000, 3'd2), 64'hC200BC00_C2003C00);
        chk("model_one", model(32'h3C004000, 32'h40003C00, 3'd0), 64'h42004200_BC003C00);
        chk("model_w45", model(32'h00000000, 32'h3C000000, 3'd1), 64'h39A8B9A8_B9A839A8);
        chk("model_ovf", model(32'h7BFF0000, 32'h7BFF0000, 3'd0), 64'h7C000000_00000000);

        @(negedge clk);
        rst_n = 1'b1;
        num1 = 32'hC2000000; num2 = 32'h3C000000; twiddle_index = 3'd2;
        @(posedge clk);
        #1;
        chk("first_after_reset", {result1, result2}, 64'hC200BC00_C2003C00);

        apply("pipe_one", 32'h3C004000, 32'h40003C00, 3'd0, 64'h42004200_BC003C00);
        apply("pipe_w45", 32'h00000000, 32'h3C000000, 3'd1, 64'h39A8B9A8_B9A839A8);
        apply("pipe_ovf", 32'h7BFF0000, 32'h7BFF0000, 3'd0, 64'h7C000000_00000000);
        apply("pipe_negj", 32'hC2000000, 32'h3C000000, 3'd2, 64'hC200BC00_C2003C00);
        #3;
        chk("hold", {result1, result2}, 64'hC200BC00_C2003C00);

        apply("k4_neg1", 32'h00000000, 32'h3C000000, 3'd4, 64'hBC000000_3C000000);
        apply("k6_posj", 32'h00000000, 32'h3C000000, 3'd6, 64'h00003C00_0000BC00);
        for (int k = 0; k < 8; k++) apply("k_sweep", 32'h3C00C000, 32'h4000BC00, 3'(k),
                                          model(32'h3C00C000, 32'h4000BC00, 3'(k)));
        apply("nan_in", 32'h7E010000, 32'h3C000000, 3'd0, 64'h7E000000_7E000000);
        apply("inf_inf", 32'h7C000000, 32'h7C000000, 3'd0, 64'h7C007E00_7E007E00);
        apply("sub_in_ftz", 32'h00018001, 32'h00000000, 3'd0, 64'h00000000_00008000);
        apply("sub_out_ftz", 32'h04000000, 32'h04010000, 3'd0, 64'h08000000_80000000);

        // reset dropped mid-cycle must clear outputs without waiting for a clock
        @(negedge clk);
        num1 = 32'h3C003C00; num2 = 32'h3C003C00; twiddle_index = 3'd0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_clear", {result1, result2}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        num1 = 32'h3C004000; num2 = 32'h40003C00; twiddle_index = 3'd0;
        @(posedge clk);
        #1;
        chk("reload_after_reset", {result1, result2}, 64'h42004200_BC003C00);

        repeat (400) begin
            @(negedge clk);
            num1 = {rh(), rh()}; num2 = {rh(), rh()}; twiddle_index = 3'($urandom);
        end
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/butterfly2p.md
BUTTERFLY2P -- requirements
Module: butterfly2p

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: num1  input  32  complex operand A; [31:16] real, [15:0] imaginary, each IEEE-754 binary16.
REQ-006 Port: num2  input  32  complex operand B; same packing as num1.
REQ-007 Port: twiddle_index  input  3  k selecting twiddle W = W8^k = exp(-j*2*pi*k/8), k = 0..7.
REQ-008 Port: result1  output  32  registered A + W*B; same packing as num1.
REQ-009 Port: result2  output  32  registered A - W*B; same packing as num1.

Function
REQ-010 The twiddle ROM SHALL hold these {real, imag} binary16 constants, with c = 0x39A8:
- k0 {3C00,0000}
- k1 {c,B9A8}
- k2 {0000,BC00}
- k3 {B9A8,B9A8}
- k4 {BC00,0000}
- k5 {B9A8,c}
- k6 {0000,3C00}
- k7 {c,c}
REQ-011 Complex product SHALL be computed as P.re = B.re*W.re - B.im*W.im and P.im = B.re*W.im + B.im*W.re, using binary16 multiply and add.
REQ-012 Each individual binary16 multiply and add/subtract SHALL round to nearest, ties-to-even.
REQ-013 Subnormal inputs and subnormal results SHALL be flushed to zero of the same sign.
REQ-014 Results whose magnitude exceeds 65504 after rounding SHALL become signed infinity (0x7C00 / 0xFC00).
REQ-015 Any NaN operand SHALL produce the canonical NaN 0x7E00; inf - inf SHALL also produce 0x7E00.
REQ-016 An exact-zero sum of opposite-signed operands SHALL be +0; sums of (-0) + (-0) SHALL be -0.
REQ-017 result1 SHALL be {A.re + P.re, A.im + P.im} and result2 SHALL be {A.re - P.re, A.im - P.im}.
REQ-018 The datapath between the inputs and the output registers SHALL be fully combinational.
REQ-019 Inputs sampled at rising edge N SHALL appear on result1/result2 immediately after edge N (latency 1 cycle).
REQ-020 The block SHALL accept a new operand set every cycle (throughput 1/cycle) and has no handshake.
REQ-021 Outputs SHALL hold their value until the next rising edge.
REQ-022 A twiddle_index change SHALL take effect at the next edge only, with no state carried between cycles.

Reset
REQ-023 While rst_n = 0, result1 and result2 SHALL be 32'h00000000, asynchronously and independent of clk.
REQ-024 On rst_n deassertion, the first rising edge with rst_n = 1 SHALL load the butterfly of the current inputs.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result.

Verification
REQ-026 Reset behaviour: rst_n = 0 with arbitrary inputs and clock running -> result1 = result2 = 00000000; the outputs clear at once when rst_n falls mid-operation.
REQ-027 Directed case, multiply by -j: num1 = C2000000 (-3), num2 = 3C000000 (1), k = 2 -> after 1 edge, result1 = C200BC00 (-3-j) and result2 = C2003C00 (-3+j).
REQ-028 Directed case, multiply by 1: num1 = 3C004000 (1+2j), num2 = 40003C00 (2+j), k = 0 -> result1 = 42004200 (3+3j) and result2 = BC003C00 (-1+j).
REQ-029 Directed case, 45-degree twiddle: num1 = 00000000, num2 = 3C000000, k = 1 -> result1 = 39A8B9A8 and result2 = B9A839A8.
REQ-030 Directed case, overflow: num1 = num2 = 7BFF0000, k = 0 -> result1 = 7C000000 (+inf) and result2 = 00000000.
REQ-031 Pipeline case: stream four different vectors on consecutive edges -> each result appears exactly one cycle after its inputs, with no bubbles.
